// File: rtl/filter_stage_scheduler.sv
// Tempo-driven stack-depth scheduler: picks the filter stack depth from BPM with hysteresis,
// commits changes only on frame starts after a stability check, and times the beat-driven zoom window.
module filter_stage_scheduler #(
    parameter int unsigned LOW_THRESH    = 100,
    parameter int unsigned HIGH_THRESH   = 140,
    parameter int unsigned HYST          = 8,
    parameter int unsigned STABLE_FRAMES = 2,
    parameter int unsigned ZOOM_CYCLES   = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        frame_start,
    input  logic [15:0] BPM_estimate,
    input  logic        beat_detected,
    output logic [1:0]  mode,
    output logic        mode_changed,
    output logic        zoom_active,
    output logic [7:0]  beat_count
);

    localparam int ZW = $clog2(ZOOM_CYCLES + 1);
    localparam logic [15:0]   LOW_T     = 16'(LOW_THRESH);
    localparam logic [15:0]   HIGH_T    = 16'(HIGH_THRESH);
    localparam logic [15:0]   HYST_T    = 16'(HYST);
    localparam logic [3:0]    SF        = 4'(STABLE_FRAMES);
    localparam logic [ZW-1:0] ZOOM_LOAD = ZW'(ZOOM_CYCLES);
    localparam logic [ZW-1:0] ZOOM_ONE  = ZW'(1);

    typedef enum logic {
        ST_STABLE,
        ST_PENDING
    } schedState_e;

    schedState_e   state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [1:0]    pend_q, pend_d;
    logic [3:0]    pcnt_q, pcnt_d;
    logic          modeChanged_q;
    logic [ZW-1:0] zoomCnt_q, zoomCnt_d;
    logic          zoomActive_q;
    logic          beat_q, beatDly_q;
    logic [7:0]    beatCount_q;

    logic          commit;
    logic          beatRise;
    logic [16:0]   hystSum;
    logic [15:0]   hystBpm;
    logic [1:0]    rawNow, rawHyst, cand;

    function automatic logic [1:0] rawMode(input logic [15:0] b);
        if (b < LOW_T) begin
            return 2'd1;
        end else if (b < HIGH_T) begin
            return 2'd2;
        end
        return 2'd3;
    endfunction

    // Downward moves are judged on BPM+HYST so a tempo hovering at a threshold cannot chatter.
    always_comb begin
        hystSum = {1'b0, BPM_estimate} + {1'b0, HYST_T};
        hystBpm = hystSum[16] ? 16'hFFFF : hystSum[15:0];
        rawNow  = rawMode(BPM_estimate);
        rawHyst = rawMode(hystBpm);
        if (!enable || BPM_estimate == 16'd0) begin
            cand = 2'd0;
        end else if (rawNow >= mode_q) begin
            cand = rawNow;
        end else if (rawHyst >= mode_q) begin
            cand = mode_q;
        end else begin
            cand = rawHyst;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        pend_d  = pend_q;
        pcnt_d  = pcnt_q;
        commit  = 1'b0;
        if (frame_start) begin
            if (cand == 2'd0 && mode_q != 2'd0) begin
                mode_d  = 2'd0;
                commit  = 1'b1;
                state_d = ST_STABLE;
            end else begin
                case (state_q)
                    ST_STABLE: begin
                        if (cand != mode_q) begin
                            if (SF == 4'd1) begin
                                mode_d = cand;
                                commit = 1'b1;
                            end else begin
                                pend_d  = cand;
                                pcnt_d  = 4'd1;
                                state_d = ST_PENDING;
                            end
                        end
                    end
                    ST_PENDING: begin
                        if (cand == mode_q) begin
                            state_d = ST_STABLE;
                        end else if (cand != pend_q) begin
                            pend_d = cand;
                            pcnt_d = 4'd1;
                        end else begin
                            pcnt_d = pcnt_q + 4'd1;
                            if (pcnt_q + 4'd1 == SF) begin
                                mode_d  = pend_q;
                                commit  = 1'b1;
                                state_d = ST_STABLE;
                            end
                        end
                    end
                    default: state_d = ST_STABLE;
                endcase
            end
        end
    end

    assign beatRise = beat_q & ~beatDly_q;

    // The next mode gates the load, so a BYPASS commit beats a simultaneous rise.
    always_comb begin
        zoomCnt_d = zoomCnt_q;
        if (commit && mode_d == 2'd0) begin
            zoomCnt_d = '0;
        end else if (beatRise && mode_d != 2'd0) begin
            zoomCnt_d = ZOOM_LOAD;
        end else if (zoomCnt_q != '0) begin
            zoomCnt_d = zoomCnt_q - ZOOM_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_STABLE;
            mode_q        <= 2'd0;
            pend_q        <= 2'd0;
            pcnt_q        <= 4'd0;
            modeChanged_q <= 1'b0;
            zoomCnt_q     <= '0;
            zoomActive_q  <= 1'b0;
            beat_q        <= 1'b0;
            beatDly_q     <= 1'b0;
            beatCount_q   <= 8'd0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            pend_q        <= pend_d;
            pcnt_q        <= pcnt_d;
            modeChanged_q <= commit;
            zoomCnt_q     <= zoomCnt_d;
            zoomActive_q  <= (zoomCnt_d != '0) && (mode_d != 2'd0);
            beat_q        <= beat_detected;
            beatDly_q     <= beat_q;
            if (beatRise) begin
                beatCount_q <= beatCount_q + 8'd1;
            end
        end
    end

    assign mode         = mode_q;
    assign mode_changed = modeChanged_q;
    assign zoom_active  = zoomActive_q;
    assign beat_count   = beatCount_q;

endmodule
